// File: rtl/spi_master.sv
// Single-byte SPI master: active-high ss, sclk idles low, MSB-first full-duplex exchange.
// sclk is divided down from sys_clk, and ss has programmable lead and lag around the clock burst.
module spi_master #(
  parameter int CLK_DIV = 4,
  parameter int SS_LEAD = 2,
  parameter int SS_LAG  = 2
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic       ss,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0] LEAD_LAST = 8'(SS_LEAD - 1);
  localparam logic [7:0] LAG_LAST  = 8'(SS_LAG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEAD = 2'd1,
    XFER = 2'd2,
    LAG  = 2'd3
  } state_t;

  state_t     state_r;
  logic [7:0] cnt_r;
  logic [3:0] phase_r;
  logic [6:0] tx_shift_r;
  logic [7:0] rx_shift_r;

  // Transfer sequencer; every bus and handshake output is registered here.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      cnt_r      <= 8'd0;
      phase_r    <= 4'd0;
      tx_shift_r <= 7'd0;
      rx_shift_r <= 8'd0;
      rx_data    <= 8'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ss         <= 1'b0;
      sclk       <= 1'b0;
      mosi       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            tx_shift_r <= tx_data[6:0];
            rx_shift_r <= 8'd0;
            mosi       <= tx_data[7];
            ss         <= 1'b1;
            busy       <= 1'b1;
            cnt_r      <= 8'd0;
            phase_r    <= 4'd0;
            state_r    <= LEAD;
          end
        end
        LEAD: begin
          if (cnt_r == LEAD_LAST) begin
            cnt_r   <= 8'd0;
            state_r <= XFER;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        XFER: begin
          if (cnt_r == DIV_LAST) begin
            cnt_r <= 8'd0;
            // Odd phases are high, so leaving one is a falling sclk edge.
            if (phase_r[0]) begin
              rx_shift_r <= {rx_shift_r[6:0], miso};
              if (phase_r != 4'd15) begin
                mosi       <= tx_shift_r[6];
                tx_shift_r <= {tx_shift_r[5:0], 1'b0};
              end
            end
            if (phase_r == 4'd15) begin
              sclk    <= 1'b0;
              state_r <= LAG;
            end else begin
              sclk    <= ~sclk;
              phase_r <= phase_r + 4'd1;
            end
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        LAG: begin
          if (cnt_r == LAG_LAST) begin
            cnt_r   <= 8'd0;
            ss      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            mosi    <= 1'b0;
            rx_data <= rx_shift_r;
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          ss      <= 1'b0;
          sclk    <= 1'b0;
          busy    <= 1'b0;
          mosi    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (default timing and the fastest timing) share the stimulus
// and are compared every cycle with a timeline model derived from the transfer start cycle.
module tb_spi_master;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] tx_data;
  bit         loop_mode;
  logic [7:0] slave_byte;

  logic [7:0] rx_w   [2];
  logic       busy_w [2];
  logic       done_w [2];
  logic       ss_w   [2];
  logic       sclk_w [2];
  logic       mosi_w [2];
  logic       miso_w [2];

  always #5 sys_clk = ~sys_clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic       smiso;
    logic [2:0] scnt;

    spi_master #(
      .CLK_DIV(g == 0 ? 4 : 1),
      .SS_LEAD(g == 0 ? 2 : 1),
      .SS_LAG (g == 0 ? 2 : 1)
    ) u_dut (
      .sys_clk(sys_clk),
      .rst    (rst),
      .start  (start),
      .tx_data(tx_data),
      .rx_data(rx_w[g]),
      .busy   (busy_w[g]),
      .done   (done_w[g]),
      .ss     (ss_w[g]),
      .sclk   (sclk_w[g]),
      .mosi   (mosi_w[g]),
      .miso   (miso_w[g])
    );

    // Slave: presents the next bit of slave_byte on every rising sclk edge.
    always @(posedge sclk_w[g] or negedge ss_w[g]) begin
      if (!ss_w[g]) begin
        scnt  <= 3'd0;
        smiso <= 1'b0;
      end else begin
        smiso <= slave_byte[3'd7 - scnt];
        scnt  <= scnt + 3'd1;
      end
    end

    assign miso_w[g] = loop_mode ? mosi_w[g] : smiso;
  end

  int p_div  [2] = '{4, 1};
  int p_lead [2] = '{2, 1};
  int p_lag  [2] = '{2, 1};

  int         errors = 0;
  int         checks = 0;
  int         cyc    = 0;
  bit         act     [2];
  int         t_acc   [2];
  logic [7:0] mtx     [2];
  logic [7:0] mrx     [2];
  logic [7:0] rx_last [2];

  bit         prev_sclk [2];
  bit         prev_ss   [2];
  int         rise_cnt  [2];
  logic [7:0] rise_bits [2];
  int         high_cnt  [2];
  int         done_cnt  [2];
  int         last_done [2];
  int         ss_rise   [2];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, got, exp);
    end
  endtask

  function automatic int xfer_len(input int i);
    return 1 + p_lead[i] + 16 * p_div[i] + p_lag[i];
  endfunction

  function automatic bit in_transfer(input int i);
    int rel;
    rel = cyc - t_acc[i];
    return act[i] && rel >= 1 && rel < xfer_len(i);
  endfunction

  task automatic check_dut(input int i);
    int         rel, n, x, p;
    logic       e_ss, e_busy, e_done, e_sclk, e_mosi;
    bit         chk_m;
    logic [7:0] e_rx;
    rel = cyc - t_acc[i];
    n   = xfer_len(i);
    e_ss = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_sclk = 1'b0; e_mosi = 1'b0;
    chk_m = 1'b1;
    e_rx  = rx_last[i];
    if (act[i] && rel >= 1 && rel < n) begin
      e_ss   = 1'b1;
      e_busy = 1'b1;
      x      = rel - 1 - p_lead[i];
      if (x < 0) begin
        e_mosi = mtx[i][7];
      end else if (x < 16 * p_div[i]) begin
        p      = x / p_div[i];
        e_sclk = (p % 2 == 1);
        e_mosi = mtx[i][7 - p / 2];
      end else begin
        chk_m = 1'b0;
      end
    end else if (act[i] && rel == n) begin
      e_done     = 1'b1;
      e_rx       = mrx[i];
      rx_last[i] = mrx[i];
    end
    chk($sformatf("ss[%0d]", i),      32'(ss_w[i]),   32'(e_ss));
    chk($sformatf("busy[%0d]", i),    32'(busy_w[i]), 32'(e_busy));
    chk($sformatf("done[%0d]", i),    32'(done_w[i]), 32'(e_done));
    chk($sformatf("sclk[%0d]", i),    32'(sclk_w[i]), 32'(e_sclk));
    chk($sformatf("rx_data[%0d]", i), 32'(rx_w[i]),   32'(e_rx));
    if (chk_m) chk($sformatf("mosi[%0d]", i), 32'(mosi_w[i]), 32'(e_mosi));
  endtask

  task automatic observe(input int i);
    if (sclk_w[i] && !prev_sclk[i]) begin
      rise_cnt[i]++;
      rise_bits[i] = {rise_bits[i][6:0], mosi_w[i]};
    end
    if (sclk_w[i]) high_cnt[i]++;
    if (done_w[i]) begin
      done_cnt[i]++;
      last_done[i] = cyc;
    end
    if (ss_w[i] && !prev_ss[i]) ss_rise[i] = cyc;
    prev_sclk[i] = sclk_w[i];
    prev_ss[i]   = ss_w[i];
  endtask

  task automatic clr_obs();
    for (int i = 0; i < 2; i++) begin
      rise_cnt[i]  = 0;
      rise_bits[i] = 8'h00;
      high_cnt[i]  = 0;
      done_cnt[i]  = 0;
      last_done[i] = -1000;
      ss_rise[i]   = -1000;
    end
  endtask

  // One sys_clk cycle: check the current cycle, then drive inputs sampled at the next edge.
  task automatic step(input bit st, input logic [7:0] tx);
    @(negedge sys_clk);
    for (int i = 0; i < 2; i++) begin
      check_dut(i);
      observe(i);
    end
    start   = st;
    tx_data = tx;
    for (int i = 0; i < 2; i++) begin
      if (rst && st && !in_transfer(i)) begin
        act[i]   = 1'b1;
        t_acc[i] = cyc;
        mtx[i]   = tx;
        mrx[i]   = loop_mode ? tx : slave_byte;
      end
    end
    @(posedge sys_clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'($urandom));
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s ss[%0d]", tag, i),      32'(ss_w[i]),   32'h0);
      chk($sformatf("%s sclk[%0d]", tag, i),    32'(sclk_w[i]), 32'h0);
      chk($sformatf("%s mosi[%0d]", tag, i),    32'(mosi_w[i]), 32'h0);
      chk($sformatf("%s busy[%0d]", tag, i),    32'(busy_w[i]), 32'h0);
      chk($sformatf("%s done[%0d]", tag, i),    32'(done_w[i]), 32'h0);
      chk($sformatf("%s rx_data[%0d]", tag, i), 32'(rx_w[i]),   32'h0);
    end
  endtask

  task automatic mid_reset();
    @(negedge sys_clk);
    rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    for (int i = 0; i < 2; i++) begin
      act[i]     = 1'b0;
      rx_last[i] = 8'h00;
    end
    @(posedge sys_clk);
    cyc++;
    step(1'b0, 8'h00);
    step(1'b1, 8'h77);
    #2 rst = 1'b1;
  endtask

  initial begin
    int         t0;
    logic [7:0] vec [3];
    rst = 1'b0; start = 1'b0; tx_data = 8'h00; loop_mode = 1'b0; slave_byte = 8'h00;
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0; t_acc[i] = 0; mtx[i] = 8'h00; mrx[i] = 8'h00; rx_last[i] = 8'h00;
      prev_sclk[i] = 1'b0; prev_ss[i] = 1'b0;
    end
    clr_obs();
    repeat (3) @(posedge sys_clk);
    #1;
    check_all_zero("reset");
    @(posedge sys_clk);
    #2 rst = 1'b1;
    idle(4);

    // Slave returns 8'h3C while 8'hA5 goes out.
    loop_mode = 1'b0; slave_byte = 8'h3C; clr_obs(); t0 = cyc;
    step(1'b1, 8'hA5);
    idle(80);
    chk("t1 mosi at rises", 32'(rise_bits[0]), 32'h0000_00A5);
    chk("t1 rise count", 32'(rise_cnt[0]), 32'd8);
    chk("t1 done latency", 32'(last_done[0] - t0), 32'd69);
    chk("t1 done count", 32'(done_cnt[0]), 32'd1);
    chk("t1 rx_data", 32'(rx_w[0]), 32'h0000_003C);
    chk("t1 fast rx_data", 32'(rx_w[1]), 32'h0000_003C);

    // Loopback with extreme patterns.
    loop_mode = 1'b1;
    vec[0] = 8'hFF; vec[1] = 8'h00; vec[2] = 8'h81;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, vec[k]);
      idle(80);
      chk($sformatf("t2 rx_data %0d", k), 32'(rx_w[0]), 32'(vec[k]));
    end

    // Fastest timing on the second instance.
    clr_obs(); t0 = cyc;
    step(1'b1, 8'h5A);
    idle(80);
    chk("t6 done latency", 32'(last_done[1] - t0), 32'd19);
    chk("t6 sclk high cycles", 32'(high_cnt[1]), 32'd8);
    chk("t6 rise count", 32'(rise_cnt[1]), 32'd8);
    chk("t6 rx_data", 32'(rx_w[1]), 32'h0000_005A);
    chk("t6 done count", 32'(done_cnt[1]), 32'd1);

    // start held through the first done launches the next transfer immediately.
    clr_obs(); t0 = cyc;
    repeat (69) step(1'b1, 8'h12);
    step(1'b1, 8'h34);
    idle(90);
    chk("t3 done count", 32'(done_cnt[0]), 32'd2);
    chk("t3 second ss rise", 32'(ss_rise[0] - t0), 32'd70);
    chk("t3 second done", 32'(last_done[0] - t0), 32'd138);
    chk("t3 rx_data", 32'(rx_w[0]), 32'h0000_0034);

    // start while busy is ignored.
    clr_obs(); t0 = cyc;
    step(1'b1, 8'hA5);
    repeat (9) step(1'b0, 8'hA5);
    step(1'b1, 8'hEE);
    idle(80);
    chk("t4 mosi at rises", 32'(rise_bits[0]), 32'h0000_00A5);
    chk("t4 done count", 32'(done_cnt[0]), 32'd1);
    chk("t4 rx_data", 32'(rx_w[0]), 32'h0000_00A5);

    // Reset in the middle of the clock burst.
    clr_obs(); t0 = cyc;
    step(1'b1, 8'h96);
    repeat (29) step(1'b0, 8'h96);
    mid_reset();
    idle(80);
    chk("t5 no done after abort", 32'(done_cnt[0]), 32'd0);
    step(1'b1, 8'hC3);
    idle(80);
    chk("t5 done after restart", 32'(done_cnt[0]), 32'd1);
    chk("t5 rx_data after restart", 32'(rx_w[0]), 32'h0000_00C3);

    // Random traffic, loopback then slave-driven.
    loop_mode = 1'b1;
    repeat (1500) step($urandom_range(0, 5) == 0, 8'($urandom));
    idle(80);
    loop_mode = 1'b0; slave_byte = 8'($urandom);
    repeat (1500) step($urandom_range(0, 5) == 0, 8'($urandom));
    idle(80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
Single-byte SPI master that drives ss/sclk/mosi and samples miso. It is the initiating end for the team's spi_slave. The host side is a start/busy/done handshake on sys_clk. The master generates sclk by dividing sys_clk, and each start performs one 8-bit MSB-first full-duplex exchange.

Parameters:
CLK_DIV, 4, sys_clk cycles per sclk half-period (each high or low phase); legal range 1..255.
SS_LEAD, 2, sys_clk cycles ss is held high, with sclk low, before the first sclk phase; legal range 1..255.
SS_LAG, 2, sys_clk cycles ss is held high, with sclk low, after the last falling sclk edge; legal range 1..255.

Ports:
sys_clk  input  1  system clock; all logic on its rising edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  request a transfer; sampled only in IDLE.
tx_data  input  8  byte to send; captured in the cycle start is accepted.
rx_data  output  8  last received byte; updated only when done pulses.
busy  output  1  high from the cycle after acceptance until done.
done  output  1  single-cycle pulse at transfer end.
ss  output  1  slave select, active-high (the slave is selected while ss=1).
sclk  output  1  serial clock; idles low.
mosi  output  1  serial data out, MSB first.
miso  input  1  serial data in, MSB first.

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: ss=0, sclk=0, mosi=0, busy=0, done=0, rx_data=8'h00.
  - Internals: state=IDLE, all counters cleared.
  - Reset mid-transfer aborts immediately: ss and sclk drop in that cycle and no done pulse is issued.
- Bus timing (mode 0 equivalent):
  - mosi is stable before each sclk rising edge; the slave samples mosi on rising edges.
  - The slave updates miso on rising edges; the master samples miso on sclk falling edges.
- IDLE:
  - If start=1 in cycle T, capture tx_data into tx_shift and clear rx_shift.
  - At T+1: ss=1, busy=1, mosi=tx_data[7], state=LEAD.
  - If start=0, remain in IDLE.
- LEAD:
  - Lasts SS_LEAD cycles, covering T+1..T+SS_LEAD, with sclk=0.
  - Then enter XFER.
- XFER:
  - 16 phases of CLK_DIV cycles each, alternating low, high, low, high, ..., ending with a high phase.
  - A half-period counter wraps at CLK_DIV-1 and a 4-bit phase counter runs 0..15.
  - Low-to-high toggle (rising edge): no master action.
  - High-to-low toggle (falling edge):
    - rx_shift <= {rx_shift[6:0], miso}.
    - If fewer than 8 bits have been sampled, mosi takes the next tx bit.
  - The 8th falling edge coincides with entry to LAG; sclk=0 from then on.
- LAG:
  - Lasts SS_LAG cycles with ss=1 and sclk=0.
  - On the cycle after LAG ends, all of the following occur together: ss=0, busy=0, done=1 (for one cycle), rx_data=rx_shift, mosi=0, state=IDLE.
- Latency: done asserts at T+1+SS_LEAD+16*CLK_DIV+SS_LAG. With default parameters that is T+69.
- start handling:
  - start while busy=1 is ignored; tx_data is not re-captured.
  - start held high across done: the done cycle is in IDLE, so a new transfer is accepted there. ss is therefore low for exactly 1 cycle between back-to-back transfers.
- rx_data holds its value between transfers. It changes only on done.
- sclk is never high outside XFER. ss never toggles inside a transfer.
- CLK_DIV=1: sclk toggles every sys_clk cycle and all rules above still hold.

Test Plan:
1. Default parameters; tx_data=8'hA5; miso driven by a slave model preloaded with 8'h3C; start pulsed at T. Required response:
   - mosi bits at the rising edges are 1,0,1,0,0,1,0,1.
   - Exactly 8 sclk rising edges.
   - done=1 only at T+69, with rx_data=8'h3C and ss=0 in that cycle.
2. mosi looped back to miso; tx_data=8'hFF, then 8'h00, then 8'h81. Required: rx_data equals each tx_data after its done; busy=0 and ss=0 in each done cycle.
3. Hold start=1 continuously for two transfers (tx 8'h12, then 8'h34). Required: the second transfer's ss rises 1 cycle after the first done, and exactly two done pulses occur.
4. Pulse start again at T+10 while busy, with tx_data changed to 8'hEE. Required: the transfer still sends 8'hA5, and only one done occurs.
5. Drive rst=0 at T+30, mid-XFER. Required: ss=0, sclk=0, busy=0 and rx_data=8'h00 immediately; no done. A new start after release completes normally.
6. CLK_DIV=1, SS_LEAD=1, SS_LAG=1; tx 8'h5A with loopback. Required: done at T+19, rx_data=8'h5A, and sclk high for exactly 8 single cycles.
